// File: rtl/manual_drive_ctrl_if.sv
// Button/switch inputs and dashboard outputs of the manual drive controller.
interface manual_drive_ctrl_if;
  logic [3:0]  button_total;
  logic [3:0]  switch_total;
  logic        power_state;
  logic [1:0]  driving_mode;
  logic [1:0]  car_state;
  logic [1:0]  turn_show;
  logic        reverse_show;
  logic [15:0] mileage;

  modport master (
    output button_total, switch_total,
    input  power_state, driving_mode, car_state, turn_show, reverse_show, mileage
  );

  modport slave (
    input  button_total, switch_total,
    output power_state, driving_mode, car_state, turn_show, reverse_show, mileage
  );
endinterface

// File: rtl/manual_drive_ctrl.sv
// Car dashboard controller: synchronised/debounced buttons, manual-gear FSM, turn signals, odometer.
// Optional odometer built only when CAR_MILEAGE_EN is defined; otherwise mileage is tied to 0.
module manual_drive_ctrl #(
  parameter int DEBOUNCE_CYC  = 2000000,
  parameter int MILE_TICK_CYC = 100000000
) (
  input  logic sys_clk,
  input  logic rst,
  manual_drive_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    NOT_STARTING = 2'b00,
    STARTING     = 2'b01,
    MOVING       = 2'b10
  } car_state_e;

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic [7:0] sync1_q, sync2_q;
  logic [3:0] btn_s, sw_s;
  logic [3:0] lvl_q, lvl_d, press_q;
  logic [DW-1:0] cnt_q [4];
  logic [DW-1:0] cnt_d [4];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.button_total, bus.switch_total};
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q[7:4];
  assign sw_s  = sync2_q[3:0];

  // A differing sample advances the count; any agreeing sample clears it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (btn_s[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_LAST) lvl_d[i] = btn_s[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      lvl_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      lvl_q   <= lvl_d;
      press_q <= lvl_d & ~lvl_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic pwr_p, mode_p, left_p, right_p;
  logic clutch, throttle, brake, rev;
  assign {pwr_p, mode_p, left_p, right_p} = press_q;
  assign {clutch, throttle, brake, rev}   = sw_s;

  car_state_e  state_q, state_d, fsm_nxt;
  logic        stall;
  logic        power_q, power_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  turn_q, turn_d;
  logic        rev_show_q, rev_show_d;
  logic        rev_prev_q;

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= NOT_STARTING;
    else     state_q <= state_d;
  end

  always_comb begin
    fsm_nxt = state_q;
    stall   = 1'b0;
    if (power_q && mode_q == 2'b01 && !pwr_p) begin
      unique case (state_q)
        NOT_STARTING: begin
          if (throttle && clutch && !brake)       fsm_nxt = STARTING;
          else if (throttle && !clutch && !brake) stall   = 1'b1;
        end
        STARTING: begin
          if (brake)                      fsm_nxt = NOT_STARTING;
          else if (throttle && !clutch)   fsm_nxt = MOVING;
        end
        MOVING: begin
          // Shifting into/out of reverse without the clutch stalls the engine.
          if ((rev ^ rev_prev_q) && !clutch) stall   = 1'b1;
          else if (brake)                    fsm_nxt = NOT_STARTING;
          else if (clutch || !throttle)      fsm_nxt = STARTING;
        end
        default: fsm_nxt = NOT_STARTING;
      endcase
    end
    state_d = (pwr_p || stall) ? NOT_STARTING : fsm_nxt;
  end

  always_comb begin
    power_d = power_q;
    mode_d  = mode_q;
    turn_d  = turn_q;
    if (pwr_p) begin
      power_d = ~power_q;
      mode_d  = power_q ? 2'b00 : 2'b01;
      turn_d  = 2'b00;
    end else if (stall) begin
      power_d = 1'b0;
      mode_d  = 2'b00;
      turn_d  = 2'b00;
    end else if (power_q) begin
      if (mode_p && state_q == NOT_STARTING)
        mode_d = (mode_q == 2'b11) ? 2'b01 : mode_q + 2'b01;
      if (left_p && !right_p)
        turn_d = (turn_q == 2'b10) ? 2'b00 : 2'b10;
      else if (right_p && !left_p)
        turn_d = (turn_q == 2'b01) ? 2'b00 : 2'b01;
    end
    rev_show_d = power_d & rev;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      power_q    <= 1'b0;
      mode_q     <= 2'b00;
      turn_q     <= 2'b00;
      rev_show_q <= 1'b0;
      rev_prev_q <= 1'b0;
    end else begin
      power_q    <= power_d;
      mode_q     <= mode_d;
      turn_q     <= turn_d;
      rev_show_q <= rev_show_d;
      rev_prev_q <= rev;
    end
  end

  assign bus.power_state  = power_q;
  assign bus.driving_mode = mode_q;
  assign bus.car_state    = state_q;
  assign bus.turn_show    = turn_q;
  assign bus.reverse_show = rev_show_q;

`ifdef CAR_MILEAGE_EN
  localparam int TW = $clog2(MILE_TICK_CYC + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(MILE_TICK_CYC - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [15:0]   mile_q, mile_d;

  // Tick counter holds outside MOVING so partial distance carries over.
  always_comb begin
    tick_d = tick_q;
    mile_d = mile_q;
    if (pwr_p) begin
      if (!power_q) mile_d = 16'h0000;
    end else if (state_q == MOVING) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        mile_d = mile_q + 16'h0001;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tick_q <= '0;
      mile_q <= 16'h0000;
    end else begin
      tick_q <= tick_d;
      mile_q <= mile_d;
    end
  end

  assign bus.mileage = mile_q;
`else
  assign bus.mileage = 16'h0000;
`endif

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Directed bench for manual_drive_ctrl with DEBOUNCE_CYC=4, MILE_TICK_CYC=10.
module tb_manual_drive_ctrl;
  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int checks   = 0;
  int failures = 0;

`ifdef CAR_MILEAGE_EN
  localparam logic [15:0] EXP_MILE_25 = 16'd2;
`else
  localparam logic [15:0] EXP_MILE_25 = 16'd0;
`endif

  manual_drive_ctrl_if bus();

  manual_drive_ctrl #(.DEBOUNCE_CYC(4), .MILE_TICK_CYC(10)) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    bus.button_total = b;
    cyc(8);
    bus.button_total = 4'b0000;
    cyc(8);
  endtask

  task automatic wait_moving(input string name);
    int k;
    k = 0;
    while (bus.car_state !== 2'b10 && k < 20) begin
      cyc(1);
      k++;
    end
    checks++;
    if (bus.car_state !== 2'b10) begin
      failures++;
      $display("FAIL %s car_state=%b exp=10 (timeout)", name, bus.car_state);
    end
  endtask

  task automatic test_reset();
    bus.button_total = 4'b0000;
    bus.switch_total = 4'b0000;
    rst = 1'b1;
    cyc(3);
    checks++;
    if ({bus.power_state, bus.driving_mode, bus.car_state, bus.turn_show, bus.reverse_show, bus.mileage} !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.power_state, bus.driving_mode, bus.car_state, bus.turn_show, bus.reverse_show, bus.mileage});
    end
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_power();
    bus.button_total = 4'b1000;
    cyc(3);
    bus.button_total = 4'b0000;
    cyc(10);
    checks++;
    if (bus.power_state !== 1'b0) begin
      failures++;
      $display("FAIL glitch_power got=%b exp=0", bus.power_state);
    end
    bus.button_total = 4'b1000;
    cyc(10);
    checks++;
    if ({bus.power_state, bus.driving_mode, bus.car_state} !== 5'b1_01_00) begin
      failures++;
      $display("FAIL power_on got=%b exp=10100", {bus.power_state, bus.driving_mode, bus.car_state});
    end
    bus.button_total = 4'b0000;
    cyc(8);
    checks++;
    if ({bus.turn_show, bus.mileage} !== 18'h0) begin
      failures++;
      $display("FAIL power_on_clear got=%h exp=0", {bus.turn_show, bus.mileage});
    end
  endtask

  task automatic test_mode();
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'b10;
    exp_seq[1] = 2'b11;
    exp_seq[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      press(4'b0100);
      checks++;
      if (bus.driving_mode !== exp_seq[i]) begin
        failures++;
        $display("FAIL mode_cycle%0d got=%b exp=%b", i, bus.driving_mode, exp_seq[i]);
      end
    end
  endtask

  task automatic test_turn();
    logic [3:0] btn [5];
    logic [1:0] exp_t [5];
    btn[0] = 4'b0010; exp_t[0] = 2'b10;
    btn[1] = 4'b0001; exp_t[1] = 2'b01;
    btn[2] = 4'b0001; exp_t[2] = 2'b00;
    btn[3] = 4'b0010; exp_t[3] = 2'b10;
    btn[4] = 4'b0011; exp_t[4] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      press(btn[i]);
      checks++;
      if (bus.turn_show !== exp_t[i]) begin
        failures++;
        $display("FAIL turn%0d got=%b exp=%b", i, bus.turn_show, exp_t[i]);
      end
    end
    press(4'b0010);
    checks++;
    if (bus.turn_show !== 2'b00) begin
      failures++;
      $display("FAIL turn_off got=%b exp=00", bus.turn_show);
    end
  endtask

  task automatic test_fsm();
    bus.switch_total = 4'b1100;
    cyc(5);
    checks++;
    if (bus.car_state !== 2'b01) begin
      failures++;
      $display("FAIL starting got=%b exp=01", bus.car_state);
    end
    press(4'b0100);
    checks++;
    if ({bus.driving_mode, bus.car_state} !== 4'b01_01) begin
      failures++;
      $display("FAIL mode_ignored got=%b exp=0101", {bus.driving_mode, bus.car_state});
    end
    bus.switch_total = 4'b0100;
    wait_moving("moving");
    // 22 cycles plus 3 cycles of brake latency leaves exactly 25 moving cycles.
    cyc(22);
    bus.switch_total = 4'b0110;
    cyc(5);
    checks++;
    if (bus.car_state !== 2'b00) begin
      failures++;
      $display("FAIL brake got=%b exp=00", bus.car_state);
    end
    checks++;
    if (bus.mileage !== EXP_MILE_25) begin
      failures++;
      $display("FAIL mileage25 got=%0d exp=%0d", bus.mileage, EXP_MILE_25);
    end
  endtask

  task automatic test_stall();
    bus.switch_total = 4'b0000;
    cyc(5);
    checks++;
    if (bus.power_state !== 1'b1) begin
      failures++;
      $display("FAIL idle_powered got=%b exp=1", bus.power_state);
    end
    bus.switch_total = 4'b0100;
    cyc(5);
    checks++;
    if ({bus.power_state, bus.driving_mode} !== 3'b000) begin
      failures++;
      $display("FAIL stall got=%b exp=000", {bus.power_state, bus.driving_mode});
    end
    bus.switch_total = 4'b0000;
    cyc(3);
  endtask

  task automatic test_reset_moving();
    int k;
    press(4'b1000);
    bus.switch_total = 4'b1100;
    cyc(5);
    bus.switch_total = 4'b0100;
    wait_moving("moving_rst");
`ifdef CAR_MILEAGE_EN
    k = 0;
    while (bus.mileage !== 16'd3 && k < 80) begin
      cyc(1);
      k++;
    end
    checks++;
    if (bus.mileage !== 16'd3 || bus.car_state !== 2'b10) begin
      failures++;
      $display("FAIL mileage3 got=%0d state=%b exp=3 state=10", bus.mileage, bus.car_state);
    end
`else
    k = 0;
    cyc(12);
    checks++;
    if (bus.mileage !== 16'd0) begin
      failures++;
      $display("FAIL mileage_off got=%0d exp=0", bus.mileage);
    end
`endif
    rst = 1'b1;
    bus.button_total = 4'b1000;
    bus.switch_total = 4'b0000;
    cyc(1);
    checks++;
    if ({bus.power_state, bus.driving_mode, bus.car_state, bus.turn_show, bus.reverse_show, bus.mileage} !== 24'h0) begin
      failures++;
      $display("FAIL rst_moving got=%h exp=0", {bus.power_state, bus.driving_mode, bus.car_state, bus.turn_show, bus.reverse_show, bus.mileage});
    end
    cyc(2);
    rst = 1'b0;
    cyc(4);
    checks++;
    if (bus.power_state !== 1'b0) begin
      failures++;
      $display("FAIL held_early got=%b exp=0", bus.power_state);
    end
    cyc(6);
    checks++;
    if (bus.power_state !== 1'b1) begin
      failures++;
      $display("FAIL held_late got=%b exp=1", bus.power_state);
    end
    bus.button_total = 4'b0000;
    cyc(8);
  endtask

  task automatic test_reverse();
    bus.switch_total = 4'b1100;
    cyc(5);
    bus.switch_total = 4'b1101;
    cyc(4);
    checks++;
    if ({bus.reverse_show, bus.car_state} !== 3'b1_01) begin
      failures++;
      $display("FAIL rev_show got=%b exp=101", {bus.reverse_show, bus.car_state});
    end
    bus.switch_total = 4'b0101;
    wait_moving("moving_rev");
    bus.switch_total = 4'b0100;
    cyc(4);
    checks++;
    if ({bus.power_state, bus.reverse_show, bus.car_state, bus.driving_mode} !== 6'b0) begin
      failures++;
      $display("FAIL rev_stall got=%b exp=000000", {bus.power_state, bus.reverse_show, bus.car_state, bus.driving_mode});
    end
    bus.switch_total = 4'b0000;
    cyc(3);
  endtask

  initial begin
    test_reset();
    test_power();
    test_mode();
    test_turn();
    test_fsm();
    test_stall();
    test_reset_moving();
    test_reverse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/manual_drive_ctrl.md
MANUAL_DRIVE_CTRL -- requirements
Module: manual_drive_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 2000000: consecutive stable cycles required before a button level is accepted (20 ms at 100 MHz).
REQ-002 Parameter MILE_TICK_CYC, default 100000000: MOVING cycles per mileage increment.
REQ-003 Clock and reset SHALL be: one clock, sys_clk, 100 MHz; reset rst is synchronous and active-high.
REQ-004 sys_clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 button_total  input  4  raw buttons {power, mode, left, right}, asynchronous, active-high.
REQ-007 switch_total  input  4  raw switches {clutch, throttle, brake, reverse}, asynchronous, active-high.
REQ-008 power_state  output  1  1 = car powered.
REQ-009 driving_mode  output  2  00 off, 01 manual, 10 semi-auto, 11 auto.
REQ-010 car_state  output  2  00 NOT_STARTING, 01 STARTING, 10 MOVING; 11 is never driven.
REQ-011 turn_show  output  2  {left, right} indicator.
REQ-012 reverse_show  output  1  reverse-gear indicator.
REQ-013 mileage  output  16  odometer count.

Function
REQ-014 Every input bit SHALL pass through a 2-flop synchroniser; switches are used synchronised but not debounced.
REQ-015 Debounce: each synchronised button SHALL change its accepted level only after DEBOUNCE_CYC consecutive cycles at the new value; any glitch restarts the count.
REQ-016 A press SHALL be a one-cycle pulse on the accepted level's 0->1 transition; releases produce no event.
REQ-017 Outputs SHALL be registered and SHALL change on the clock edge after the press pulse or the synchronised switch condition.
REQ-018 A power press SHALL toggle power_state. Power-on SHALL set driving_mode=01, car_state=00, turn_show=00 and mileage=0. Power-off SHALL force driving_mode, car_state, turn_show and reverse_show to 0.
REQ-019 A power press SHALL take priority: all other button events and transitions in that cycle are ignored.
REQ-020 A mode press, when powered and car_state=00, SHALL cycle driving_mode 01->10->11->01; otherwise it is ignored.
REQ-021 The car_state FSM SHALL be active only when powered and driving_mode=01, and SHALL hold otherwise. Brake has the highest priority among switch conditions.
- NOT_STARTING: throttle&clutch&!brake -> STARTING; throttle&!clutch&!brake -> power-off (stall).
- STARTING: brake -> NOT_STARTING; throttle&!clutch -> MOVING.
- MOVING: brake -> NOT_STARTING; clutch|!throttle -> STARTING.
REQ-022 In MOVING, a change of the synchronised reverse switch while clutch=0 SHALL cause power-off in the same cycle the change is sampled.
REQ-023 reverse_show SHALL equal power_state & synchronised reverse.
REQ-024 Turn signals, when powered:
- left press: turn_show 00/01 -> 10, 10 -> 00.
- right press: 00/10 -> 01, 01 -> 00.
- left and right pressed in the same cycle: no change.
REQ-025 Mileage: a tick counter SHALL run only while car_state=10. mileage SHALL increment when the counter reaches MILE_TICK_CYC-1, and the counter then returns to 0. The counter SHALL hold its value outside MOVING. mileage wraps 16'hFFFF -> 0.

Reset
REQ-026 While rst=1 at a clock edge, the following SHALL be set to 0: all outputs, debounce counters, accepted button levels, synchroniser flops and the tick counter.
REQ-027 Reset SHALL override every concurrent event, including a press pulse in the same cycle. A press in progress at reset SHALL need a full DEBOUNCE_CYC after reset release before it is recognised.

Configuration
REQ-028 With macro CAR_MILEAGE_EN defined, the tick counter and mileage register SHALL be built as in REQ-025.
REQ-029 Without CAR_MILEAGE_EN, no counter logic SHALL exist and mileage SHALL be constant 0.

Verification (DEBOUNCE_CYC=4, MILE_TICK_CYC=10)
REQ-030 Power pulse of 3 cycles -> no change. Power held for 10 cycles -> power_state=1, driving_mode=01, car_state=00.
REQ-031 Powered, manual: clutch=1, throttle=1 -> car_state=01; then clutch=0 -> 10; then brake=1 -> 00.
REQ-032 NOT_STARTING: throttle=1, clutch=0 -> power_state=0, driving_mode=00.
REQ-033 MOVING for 25 cycles with CAR_MILEAGE_EN -> mileage=2. Same stimulus without the macro -> mileage=0.
REQ-034 Left press -> turn_show=10; right press -> 01; right press -> 00; left and right in the same cycle -> unchanged.
REQ-035 rst asserted while MOVING with mileage=3 -> all outputs 0 on the next edge; a held power button is not recognised until 4+ cycles after rst release.
